// File: rtl/rega_tank_ctrl_if.sv
//--------------------------------------------------------------------
// Module : rega_tank_ctrl_if
// Brief  : Sensor, request and actuator bundle of the tank controller.
// Rev    : 1.0
//--------------------------------------------------------------------
`default_nettype none

interface rega_tank_ctrl_if #(
   parameter int LEVELS = 3
);
   logic [LEVELS-1:0] level;
   logic              asp_req;
   logic              adub_req;
   logic              fault_clr;
   logic              valve_in;
   logic              mixer;
   logic              clean;
   logic              spray_en;
   logic              fault;
   logic [2:0]        state;

   modport master (
      output level, asp_req, adub_req, fault_clr,
      input  valve_in, mixer, clean, spray_en, fault, state
   );

   modport slave (
      input  level, asp_req, adub_req, fault_clr,
      output valve_in, mixer, clean, spray_en, fault, state
   );
endinterface

`default_nettype wire

// File: rtl/rega_tank_ctrl.sv
//--------------------------------------------------------------------
// Module : rega_tank_ctrl
// Brief  : Tank / fertigation sequencer with level-code and timeout fault.
// Rev    : 1.0
//--------------------------------------------------------------------
`default_nettype none

module rega_tank_ctrl #(
   parameter int LEVELS     = 3,
   parameter int MIX_CYCLES = 16,
   parameter int TIMEOUT    = 1024
) (
   input  wire logic     clk,
   input  wire logic     reset,
   rega_tank_ctrl_if.slave bus
);

   localparam int c_MAXC = (MIX_CYCLES > TIMEOUT) ? MIX_CYCLES : TIMEOUT;
   localparam int c_CW   = (c_MAXC < 2) ? 1 : $clog2(c_MAXC);
   localparam logic [c_CW-1:0] c_MIX_LAST = c_CW'(MIX_CYCLES - 1);
   localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SPRAY = 3'd1,
      MIX   = 3'd2,
      CLEAN = 3'd3,
      FILL  = 3'd4,
      FAULT = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [c_CW-1:0]   r_count;
   logic              w_empty;
   logic              w_full;
   logic              w_bad;
   logic              w_bottom;
   logic              w_count_en;

   assign w_empty  = (bus.level == '0);
   assign w_full   = &bus.level;
   // A wet sensor above a dry one cannot happen in a real thermometer gauge.
   assign w_bad    = |(bus.level[LEVELS-1:1] & ~bus.level[LEVELS-2:0]);
   assign w_bottom = (bus.level == LEVELS'(1));

   always_comb begin
      w_next = r_state;
      if (r_state != FAULT && w_bad) begin
         w_next = FAULT;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_empty)          w_next = FILL;
               else if (bus.asp_req) w_next = SPRAY;
            end
            SPRAY: begin
               if (!bus.asp_req)      w_next = IDLE;
               else if (w_empty)      w_next = FILL;
               else if (bus.adub_req) w_next = MIX;
            end
            MIX: begin
               if (w_empty)                              w_next = FILL;
               else if (r_count == c_MIX_LAST || w_bottom) w_next = CLEAN;
            end
            CLEAN: begin
               if (w_empty)                 w_next = FILL;
               else if (r_count == c_TO_LAST) w_next = FAULT;
            end
            FILL: begin
               if (w_full)                  w_next = IDLE;
               else if (r_count == c_TO_LAST) w_next = FAULT;
            end
            FAULT: begin
               if (bus.fault_clr) w_next = IDLE;
            end
            default: w_next = IDLE;
         endcase
      end
   end

   assign w_count_en = (r_state == MIX) || (r_state == CLEAN) || (r_state == FILL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state || !w_count_en) begin
            r_count <= '0;
         end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign bus.valve_in = (r_state == FILL);
   assign bus.mixer    = (r_state == MIX);
   assign bus.clean    = (r_state == CLEAN);
   assign bus.spray_en = (r_state == SPRAY) || (r_state == MIX);
   assign bus.fault    = (r_state == FAULT);
   assign bus.state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rega_tank_ctrl.sv
//--------------------------------------------------------------------
// Module : tb_rega_tank_ctrl
// Brief  : Randomised and directed bench for rega_tank_ctrl.
// Rev    : 1.0
//--------------------------------------------------------------------
`default_nettype none

module tb_rega_tank_ctrl;

   localparam int c_LEVELS = 3;
   localparam int c_MIX    = 16;
   localparam int c_TO     = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   m_state;
   int   m_cnt;
   logic [7:0] act;

   rega_tank_ctrl_if #(.LEVELS(c_LEVELS)) bus ();

   rega_tank_ctrl #(
      .LEVELS     (c_LEVELS),
      .MIX_CYCLES (c_MIX),
      .TIMEOUT    (c_TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign act = {bus.state, bus.valve_in, bus.mixer, bus.clean, bus.spray_en, bus.fault};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {state, valve_in, mixer, clean, spray_en, fault} for a state code.
   function automatic logic [7:0] exp_vec(input int s);
      logic [2:0] code;
      code = s[2:0];
      return {code, s == 4, s == 2, s == 3, (s == 1) || (s == 2), s == 5};
   endfunction

   // m_cnt counts cycles already spent in the current state before this edge.
   function automatic int ref_next(input int s, input int cnt, input logic [2:0] lvl,
                                   input logic asp, input logic adub, input logic clr);
      int  l;
      int  spent;
      bit  empty;
      bit  full;
      bit  bad;
      l     = int'(lvl);
      spent = cnt + 1;
      empty = (l == 0);
      full  = (l == 7);
      bad   = ((l & (l + 1)) != 0);
      if (s == 5) return clr ? 0 : 5;
      if (bad) return 5;
      case (s)
         0: return empty ? 4 : (asp ? 1 : 0);
         1: return !asp ? 0 : (empty ? 4 : (adub ? 2 : 1));
         2: return empty ? 4 : ((spent == c_MIX || l == 1) ? 3 : 2);
         3: return empty ? 4 : ((spent >= c_TO) ? 5 : 3);
         4: return full ? 0 : ((spent >= c_TO) ? 5 : 4);
         default: return 0;
      endcase
   endfunction

   task automatic step(input logic [2:0] lvl, input logic asp, input logic adub, input logic clr);
      int nxt;
      bus.level     = lvl;
      bus.asp_req   = asp;
      bus.adub_req  = adub;
      bus.fault_clr = clr;
      @(posedge clk);
      nxt     = ref_next(m_state, m_cnt, lvl, asp, adub, clr);
      m_cnt   = (nxt == m_state) ? m_cnt + 1 : 0;
      m_state = nxt;
      #1;
      bus.fault_clr = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.level = 3'b000; bus.asp_req = 0; bus.adub_req = 0; bus.fault_clr = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (act !== 8'h00) begin
         errors++; $display("FAIL reset_hold act=%h exp=%h", act, 8'h00);
      end
      reset = 1'b0;
      m_state = 0; m_cnt = 0;
      checks++;
      if (act !== 8'h00) begin
         errors++; $display("FAIL reset_release act=%h exp=%h", act, 8'h00);
      end
      step(3'b000, 0, 0, 0);
      step(3'b001, 0, 0, 0);
      step(3'b011, 0, 0, 0);
      checks++;
      if (act !== exp_vec(4) || act !== exp_vec(m_state)) begin
         errors++; $display("FAIL fill_partial act=%h exp=%h", act, exp_vec(4));
      end
      step(3'b111, 0, 0, 0);
      checks++;
      if (act !== exp_vec(0) || act !== exp_vec(m_state)) begin
         errors++; $display("FAIL fill_full act=%h exp=%h", act, exp_vec(0));
      end
   endtask

   task automatic test_spray;
      for (int i = 0; i < 5; i++) begin
         step(3'b111, 1, 0, 0);
         checks++;
         if (act !== exp_vec(m_state) || bus.spray_en !== 1'b1) begin
            errors++; $display("FAIL spray_on act=%h exp=%h", act, exp_vec(m_state));
         end
      end
      step(3'b111, 0, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || bus.state !== 3'd0) begin
         errors++; $display("FAIL spray_off act=%h exp=%h", act, exp_vec(0));
      end
   endtask

   task automatic test_mix;
      int mix_cycles;
      mix_cycles = 0;
      step(3'b111, 1, 1, 0);
      for (int i = 0; i < 40; i++) begin
         step(3'b111, 1, 1, 0);
         checks++;
         if (act !== exp_vec(m_state)) begin
            errors++; $display("FAIL mix_seq act=%h exp=%h", act, exp_vec(m_state));
         end
         if (bus.mixer === 1'b1) mix_cycles++;
         if (bus.clean === 1'b1) break;
      end
      checks++;
      if (mix_cycles != c_MIX || bus.clean !== 1'b1) begin
         errors++; $display("FAIL mix_len act=%0d exp=%0d", mix_cycles, c_MIX);
      end
      step(3'b000, 1, 1, 0);
      checks++;
      if (act !== exp_vec(m_state) || bus.valve_in !== 1'b1) begin
         errors++; $display("FAIL clean_empty act=%h exp=%h", act, exp_vec(4));
      end
      step(3'b001, 0, 0, 0);
      step(3'b011, 0, 0, 0);
      step(3'b111, 0, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || bus.state !== 3'd0) begin
         errors++; $display("FAIL refill act=%h exp=%h", act, exp_vec(0));
      end
   endtask

   task automatic test_mix_low;
      int clean_cycles;
      clean_cycles = 0;
      step(3'b111, 1, 1, 0);
      step(3'b111, 1, 1, 0);
      step(3'b111, 1, 1, 0);
      step(3'b011, 1, 1, 0);
      step(3'b001, 1, 1, 0);
      checks++;
      if (act !== exp_vec(m_state) || bus.clean !== 1'b1 || bus.mixer !== 1'b0) begin
         errors++; $display("FAIL mix_low act=%h exp=%h", act, exp_vec(3));
      end
      clean_cycles = 1;
      for (int i = 0; i < 20; i++) begin
         step(3'b001, 0, 0, 0);
         if (bus.clean === 1'b1) clean_cycles++;
         if (bus.fault === 1'b1) break;
      end
      checks++;
      if (clean_cycles != c_TO || act !== exp_vec(m_state) || bus.fault !== 1'b1) begin
         errors++; $display("FAIL clean_timeout act=%0d exp=%0d", clean_cycles, c_TO);
      end
      step(3'b111, 0, 0, 1);
   endtask

   task automatic test_timeout;
      int fill_cycles;
      fill_cycles = 0;
      step(3'b000, 0, 0, 0);
      if (bus.valve_in === 1'b1) fill_cycles++;
      for (int i = 0; i < 20; i++) begin
         step(3'b011, 0, 0, 0);
         checks++;
         if (act !== exp_vec(m_state)) begin
            errors++; $display("FAIL fill_seq act=%h exp=%h", act, exp_vec(m_state));
         end
         if (bus.valve_in === 1'b1) fill_cycles++;
         if (bus.fault === 1'b1) break;
      end
      checks++;
      if (fill_cycles != c_TO || act !== exp_vec(5)) begin
         errors++; $display("FAIL fill_timeout act=%0d exp=%0d", fill_cycles, c_TO);
      end
      step(3'b000, 1, 1, 0);
      step(3'b101, 1, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || act !== exp_vec(5)) begin
         errors++; $display("FAIL fault_hold act=%h exp=%h", act, exp_vec(5));
      end
      step(3'b011, 0, 0, 1);
      step(3'b011, 0, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || act !== exp_vec(0)) begin
         errors++; $display("FAIL fault_clr act=%h exp=%h", act, exp_vec(0));
      end
   endtask

   task automatic test_bad_reset;
      step(3'b111, 1, 0, 0);
      step(3'b101, 1, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || act !== exp_vec(5)) begin
         errors++; $display("FAIL bad_code act=%h exp=%h", act, exp_vec(5));
      end
      step(3'b101, 0, 0, 1);
      step(3'b101, 0, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || act !== exp_vec(5)) begin
         errors++; $display("FAIL bad_refault act=%h exp=%h", act, exp_vec(5));
      end
      step(3'b000, 0, 0, 1);
      step(3'b000, 0, 0, 0);
      checks++;
      if (act !== exp_vec(m_state) || bus.valve_in !== 1'b1) begin
         errors++; $display("FAIL pre_reset act=%h exp=%h", act, exp_vec(4));
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (act !== 8'h00) begin
         errors++; $display("FAIL async_reset act=%h exp=%h", act, 8'h00);
      end
      #2 reset = 1'b0;
      m_state = 0; m_cnt = 0;
   endtask

   task automatic test_random;
      logic [2:0] lvl;
      logic [2:0] codes [4];
      codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b011; codes[3] = 3'b111;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) lvl = 3'($urandom_range(7));
         else                         lvl = codes[$urandom_range(3)];
         step(lvl, 1'($urandom_range(1)), 1'($urandom_range(1)),
              $urandom_range(7) == 0);
         checks++;
         if (act !== exp_vec(m_state)) begin
            errors++; $display("FAIL random act=%h exp=%h step=%0d", act, exp_vec(m_state), i);
         end
         checks++;
         if (int'(bus.valve_in) + int'(bus.mixer) + int'(bus.clean) > 1) begin
            errors++; $display("FAIL onehot act=%b%b%b exp=at_most_one", bus.valve_in, bus.mixer, bus.clean);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_state = 0;
      m_cnt = 0;
      test_reset;
      test_spray;
      test_mix;
      test_mix_low;
      test_timeout;
      test_bad_reset;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
